// File: rtl/multiplicador_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Contents:
//   estado_t   - controller states (IDLE, CALC, FIN)
//   cnt_width  - bit width of a counter that must hold the value w
package multiplicador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } estado_t;

    // Counter width able to represent 0..w inclusive
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/multiplicador_datapath.sv
// Datapath of the shift-add multiplier: operand magnitudes, accumulator,
// iteration counter and sign correction of the final product.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   load         - capture operands, clear accumulator and counter
//   step         - one radix-2 iteration
//   signed_mode  - operands are two's complement (sampled with load)
//   A, B         - multiplicand / multiplier
//   producto_c   - sign-corrected product (combinational from registers)
//   cuenta       - iterations completed since load
module multiplicador_datapath
    import multiplicador_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   producto_c,
    output logic [CW-1:0]        cuenta
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               neg;

    logic [WIDTH-1:0]   mag_a_c;
    logic [WIDTH-1:0]   mag_b_c;

    // Magnitudes; -2^(W-1) negates to itself, which read unsigned is 2^(W-1)
    always_comb begin
        mag_a_c = (signed_mode && A[WIDTH-1]) ? WIDTH'(-A) : A;
        mag_b_c = (signed_mode && B[WIDTH-1]) ? WIDTH'(-B) : B;
    end

    // Multiplicand is pre-shifted each step, so acc += mcand equals acc += |A| << cuenta
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            cuenta <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_a_c};
            mplier <= mag_b_c;
            neg    <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
            cuenta <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cuenta <= cuenta + CW'(1);
        end
    end

    // Two's-complement negation of a zero accumulator is zero
    always_comb begin
        producto_c = neg ? (2*WIDTH)'(-acc) : acc;
    end

endmodule

// File: rtl/multiplicador_secuencial.sv
// Sequential radix-2 shift-add multiplier, one partial product per clock.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   start        - request, honoured only when idle
//   signo        - two's-complement operands (only if SIGNED_EN=1)
//   A, B         - multiplicand / multiplier, sampled with start
//   resultado    - registered product, held until the next done
//   done         - one-cycle pulse when resultado is new
//   busy         - operation in progress (decoded from the state register)
module multiplicador_secuencial
    import multiplicador_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signo,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   resultado,
    output logic                 done,
    output logic                 busy
);

    localparam int unsigned CW = cnt_width(WIDTH);

    estado_t            estado;
    estado_t            estado_sig;
    logic               load;
    logic               step;
    logic               finish;
    logic               signed_mode_c;
    logic [CW-1:0]      cuenta;
    logic [2*WIDTH-1:0] producto_c;

    assign signed_mode_c = SIGNED_EN & signo;

    multiplicador_datapath #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_datapath (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .step        (step),
        .signed_mode (signed_mode_c),
        .A           (A),
        .B           (B),
        .producto_c  (producto_c),
        .cuenta      (cuenta)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado <= IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next state and datapath strobes
    always_comb begin
        estado_sig = estado;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        unique case (estado)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    estado_sig = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                // This edge performs the last of WIDTH iterations
                if (cuenta == CW'(WIDTH - 1)) begin
                    estado_sig = FIN;
                end
            end
            FIN: begin
                finish     = 1'b1;
                estado_sig = IDLE;
            end
            default: begin
                estado_sig = IDLE;
            end
        endcase
    end

    // Output register: product captured once per operation, done pulses one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resultado <= '0;
            done      <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                resultado <= producto_c;
            end
        end
    end

    assign busy = (estado != IDLE);

endmodule
